// File: rtl/tx_arbiter.sv
// tx_arbiter: shares one UART TX framer between NUM_REQ algo engines.
// Each engine owns a one-deep timestamped slot; slots are granted round-robin, one frame at a time.
module tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ACK_TIMEOUT = 64,
    parameter int TS_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [8*NUM_REQ-1:0]  req_addr,
    input  logic [8*NUM_REQ-1:0]  req_buysell,
    output logic [7:0]            tx_addr,
    output logic [7:0]            tx_buysell,
    output logic [TS_WIDTH-1:0]   tx_timestamp,
    output logic                  tx_dv,
    input  logic                  tx_busy,
    output logic [NUM_REQ-1:0]    pending,
    output logic [NUM_REQ-1:0]    overflow,
    output logic                  timeout,
    input  logic                  clear_flags,
    output logic [1:0]            dbg_state
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW    = IDX_W + 1;
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [TS_WIDTH-1:0]   ts_cnt_q, ts_cnt_d;
    logic [CNT_W-1:0]      ack_cnt_q, ack_cnt_d;
    logic [7:0]            slot_addr_q [NUM_REQ];
    logic [7:0]            slot_addr_d [NUM_REQ];
    logic [7:0]            slot_bs_q   [NUM_REQ];
    logic [7:0]            slot_bs_d   [NUM_REQ];
    logic [TS_WIDTH-1:0]   slot_ts_q   [NUM_REQ];
    logic [TS_WIDTH-1:0]   slot_ts_d   [NUM_REQ];
    logic [NUM_REQ-1:0]    pending_q, pending_d;
    logic [NUM_REQ-1:0]    overflow_q, overflow_d;
    logic                  timeout_q, timeout_d;
    logic                  tx_dv_q, tx_dv_d;
    logic [7:0]            tx_addr_q, tx_addr_d;
    logic [7:0]            tx_buysell_q, tx_buysell_d;
    logic [TS_WIDTH-1:0]   tx_ts_q, tx_ts_d;

    logic [CW-1:0]         cand;
    logic                  grant_found;
    logic [IDX_W-1:0]      grant_idx;
    logic                  do_grant;
    logic [NUM_REQ-1:0]    grant_oh;
    logic [NUM_REQ-1:0]    drop_vec;
    logic                  timeout_set;

    // First pending slot strictly after rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + CW'(k);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end
            if (!grant_found && pending_q[cand[IDX_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign do_grant = (state_q == IDLE) && grant_found;
    assign grant_oh = do_grant ? (NUM_REQ'(1) << grant_idx) : '0;

    // A slot being granted this cycle may refill in the same cycle without overflowing.
    always_comb begin
        pending_d = pending_q;
        drop_vec  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            slot_addr_d[i] = slot_addr_q[i];
            slot_bs_d[i]   = slot_bs_q[i];
            slot_ts_d[i]   = slot_ts_q[i];
            if (req_valid[i] && (!pending_q[i] || grant_oh[i])) begin
                slot_addr_d[i] = req_addr[8*i +: 8];
                slot_bs_d[i]   = req_buysell[8*i +: 8];
                slot_ts_d[i]   = ts_cnt_q;
                pending_d[i]   = 1'b1;
            end else begin
                if (grant_oh[i]) begin
                    pending_d[i] = 1'b0;
                end
                if (req_valid[i]) begin
                    drop_vec[i] = 1'b1;
                end
            end
        end
    end

    // Framer handshake: tx_dv is held with stable payload until tx_busy is seen high
    // (frame accepted) or ACK_TIMEOUT cycles pass; tx_busy low afterwards means frame done.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        ack_cnt_d    = ack_cnt_q;
        tx_dv_d      = tx_dv_q;
        tx_addr_d    = tx_addr_q;
        tx_buysell_d = tx_buysell_q;
        tx_ts_d      = tx_ts_q;
        timeout_set  = 1'b0;
        ts_cnt_d     = ts_cnt_q + TS_WIDTH'(1);
        case (state_q)
            IDLE: begin
                if (do_grant) begin
                    tx_addr_d    = slot_addr_q[grant_idx];
                    tx_buysell_d = slot_bs_q[grant_idx];
                    tx_ts_d      = slot_ts_q[grant_idx];
                    rr_ptr_d     = grant_idx;
                    tx_dv_d      = 1'b1;
                    ack_cnt_d    = '0;
                    state_d      = SEND;
                end
            end
            SEND: begin
                if (tx_busy) begin
                    tx_dv_d = 1'b0;
                    state_d = WAIT_DONE;
                end else if (ack_cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    tx_dv_d     = 1'b0;
                    timeout_set = 1'b1;
                    state_d     = IDLE;
                end else begin
                    ack_cnt_d = ack_cnt_q + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                tx_dv_d = 1'b0;
                state_d = IDLE;
            end
        endcase
        overflow_d = (clear_flags ? '0 : overflow_q) | drop_vec;
        timeout_d  = (clear_flags ? 1'b0 : timeout_q) | timeout_set;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= IDX_W'(NUM_REQ - 1);
            ts_cnt_q     <= '0;
            ack_cnt_q    <= '0;
            pending_q    <= '0;
            overflow_q   <= '0;
            timeout_q    <= 1'b0;
            tx_dv_q      <= 1'b0;
            tx_addr_q    <= '0;
            tx_buysell_q <= '0;
            tx_ts_q      <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_addr_q[i] <= '0;
                slot_bs_q[i]   <= '0;
                slot_ts_q[i]   <= '0;
            end
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            ts_cnt_q     <= ts_cnt_d;
            ack_cnt_q    <= ack_cnt_d;
            pending_q    <= pending_d;
            overflow_q   <= overflow_d;
            timeout_q    <= timeout_d;
            tx_dv_q      <= tx_dv_d;
            tx_addr_q    <= tx_addr_d;
            tx_buysell_q <= tx_buysell_d;
            tx_ts_q      <= tx_ts_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_addr_q[i] <= slot_addr_d[i];
                slot_bs_q[i]   <= slot_bs_d[i];
                slot_ts_q[i]   <= slot_ts_d[i];
            end
        end
    end

    assign tx_addr      = tx_addr_q;
    assign tx_buysell   = tx_buysell_q;
    assign tx_timestamp = tx_ts_q;
    assign tx_dv        = tx_dv_q;
    assign pending      = pending_q;
    assign overflow     = overflow_q;
    assign timeout      = timeout_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: directed scenarios plus a random run against a transaction-level model
// of slots, round-robin pointer and a single outstanding frame.
module tb_tx_arbiter;
    localparam int N   = 4;
    localparam int ACK = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [8*N-1:0]  req_addr, req_buysell;
    logic [7:0]      tx_addr, tx_buysell;
    logic [31:0]     tx_timestamp;
    logic            tx_dv, tx_busy, timeout, clear_flags;
    logic [N-1:0]    pending, overflow;
    logic [1:0]      dbg_state;

    always #5 clk = ~clk;

    tx_arbiter #(.NUM_REQ(N), .ACK_TIMEOUT(ACK), .TS_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_buysell(req_buysell), .tx_addr(tx_addr), .tx_buysell(tx_buysell),
        .tx_timestamp(tx_timestamp), .tx_dv(tx_dv), .tx_busy(tx_busy),
        .pending(pending), .overflow(overflow), .timeout(timeout),
        .clear_flags(clear_flags), .dbg_state(dbg_state)
    );

    int n_cmp = 0;
    int n_err = 0;

    // reference model: slot contents, rr pointer, one outstanding frame
    logic [N-1:0] m_full;
    logic [7:0]   m_addr [N];
    logic [7:0]   m_bs   [N];
    logic [31:0]  m_ts   [N];
    int           m_rr;
    logic         m_dv, m_acked;
    int           m_age;
    logic [7:0]   m_tx_addr, m_tx_bs;
    logic [31:0]  m_tx_ts;
    logic [N-1:0] m_ovf;
    logic         m_tmo;
    logic [31:0]  m_tsc;
    logic [47:0]  exp_q[$];

    // framer emulation: 0 never acks, 1 fixed wait/len, 2 random wait/len
    int fr_mode = 0, fr_phase = 0, fr_cnt = 0, fr_wait_cfg = 0, fr_len_cfg = 1;
    logic dv_prev = 1'b0, dv_rose = 1'b0;

    function automatic int m_search();
        for (int k = 1; k <= N; k++) begin
            if (m_full[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_full = '0; m_rr = N - 1; m_dv = 1'b0; m_acked = 1'b0; m_age = 0;
        m_tx_addr = '0; m_tx_bs = '0; m_tx_ts = '0; m_ovf = '0; m_tmo = 1'b0; m_tsc = '0;
        for (int i = 0; i < N; i++) begin m_addr[i] = '0; m_bs[i] = '0; m_ts[i] = '0; end
        exp_q.delete();
        fr_phase = 0; fr_cnt = 0;
    endtask

    task automatic step(input logic [N-1:0] v, input logic [8*N-1:0] a,
                        input logic [8*N-1:0] b, input logic clr);
        int g;
        logic busy, tmo_set;
        logic [N-1:0] full_old, ovf_set;
        busy = 1'b0; tmo_set = 1'b0; ovf_set = '0;
        if (fr_mode != 0) begin
            if (fr_phase == 0 && m_dv) begin
                fr_phase = 1;
                fr_cnt = (fr_mode == 2) ? $urandom_range(0, 6) : fr_wait_cfg;
            end
            if (fr_phase == 1) begin
                if (fr_cnt == 0) begin
                    fr_phase = 2;
                    fr_cnt = (fr_mode == 2) ? $urandom_range(1, 8) : fr_len_cfg;
                end else fr_cnt--;
            end
            if (fr_phase == 2) begin
                busy = 1'b1; fr_cnt--;
                if (fr_cnt == 0) fr_phase = 0;
            end
        end
        full_old = m_full; g = -1;
        if (m_dv) begin
            if (busy) begin m_dv = 1'b0; m_acked = 1'b1; end
            else if (m_age == ACK - 1) begin m_dv = 1'b0; tmo_set = 1'b1; end
            else m_age++;
        end else if (m_acked) begin
            if (!busy) m_acked = 1'b0;
        end else begin
            g = m_search();
            if (g >= 0) begin
                m_tx_addr = m_addr[g]; m_tx_bs = m_bs[g]; m_tx_ts = m_ts[g];
                m_full[g] = 1'b0; m_rr = g; m_dv = 1'b1; m_age = 0;
                exp_q.push_back({m_addr[g], m_bs[g], m_ts[g]});
            end
        end
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                if (!full_old[i] || g == i) begin
                    m_full[i] = 1'b1; m_addr[i] = a[8*i +: 8]; m_bs[i] = b[8*i +: 8]; m_ts[i] = m_tsc;
                end else ovf_set[i] = 1'b1;
            end
        end
        if (clr) begin m_ovf = '0; m_tmo = 1'b0; end
        m_ovf = m_ovf | ovf_set;
        m_tmo = m_tmo | tmo_set;
        m_tsc = m_tsc + 32'd1;
        req_valid = v; req_addr = a; req_buysell = b; tx_busy = busy; clear_flags = clr;
        dv_prev = tx_dv;
        @(posedge clk); #1;
        dv_rose = !dv_prev && tx_dv;
    endtask

    task automatic idle();
        step('0, '0, '0, 1'b0);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((m_dv || m_acked || m_full != '0 || fr_phase != 0) && guard < 500) begin
            idle(); guard++;
        end
        n_cmp++;
        if (guard >= 500) begin n_err++; $display("FAIL drain: got %0d cycles, required < 500", guard); end
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = '0; req_addr = '0; req_buysell = '0; tx_busy = 1'b0; clear_flags = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = '0; req_addr = '0; req_buysell = '0; tx_busy = 1'b0; clear_flags = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (tx_dv !== 1'b0) begin n_err++; $display("FAIL reset_tx_dv: got %b required 0", tx_dv); end
        n_cmp++; if (pending !== '0) begin n_err++; $display("FAIL reset_pending: got %b required 0", pending); end
        n_cmp++; if (overflow !== '0 || timeout !== 1'b0) begin n_err++; $display("FAIL reset_flags: got %b/%b required 0/0", overflow, timeout); end
        n_cmp++; if ({tx_addr, tx_buysell, tx_timestamp} !== 48'h0) begin n_err++; $display("FAIL reset_payload: got %h required 0", {tx_addr, tx_buysell, tx_timestamp}); end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        logic [8*N-1:0] a, b;
        int guard;
        fr_mode = 1; fr_wait_cfg = 2; fr_len_cfg = 20;
        repeat (10) idle();
        a = '0; b = '0; a[15:8] = 8'h05; b[15:8] = 8'h01;
        step(4'b0010, a, b, 1'b0);
        n_cmp++; if (pending !== 4'b0010 || tx_dv !== 1'b0) begin n_err++; $display("FAIL single_pending: got %b dv %b required 0010 dv 0", pending, tx_dv); end
        idle();
        n_cmp++; if (tx_dv !== 1'b1) begin n_err++; $display("FAIL single_dv_latency: got %b required 1", tx_dv); end
        n_cmp++; if ({tx_addr, tx_buysell} !== 16'h0501) begin n_err++; $display("FAIL single_payload: got %h required 0501", {tx_addr, tx_buysell}); end
        n_cmp++; if (tx_timestamp !== 32'd10) begin n_err++; $display("FAIL single_timestamp: got %0d required 10", tx_timestamp); end
        n_cmp++; if (pending !== '0) begin n_err++; $display("FAIL single_pending_clr: got %b required 0", pending); end
        guard = 0;
        while (tx_dv && guard < 100) begin idle(); guard++; end
        drain();
        n_cmp++; if (tx_dv !== 1'b0 || pending !== '0 || tx_addr !== 8'h05) begin n_err++; $display("FAIL single_done: got dv %b pend %b addr %h required 0 0 05", tx_dv, pending, tx_addr); end
        $display("info: state code after single frame = %0d", dbg_state);
    endtask

    task automatic test_round_robin();
        logic [7:0] got[$];
        logic [7:0] want[6] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h22};
        logic [8*N-1:0] a, b;
        logic [N-1:0] v;
        int guard;
        do_reset();
        fr_mode = 1; fr_wait_cfg = 1; fr_len_cfg = 3;
        for (int i = 0; i < N; i++) begin a[8*i +: 8] = 8'h10 + 8'(i); b[8*i +: 8] = 8'h80 + 8'(i); end
        step(4'hF, a, b, 1'b0);
        guard = 0;
        while (got.size() < 6 && guard < 400) begin
            v = '0; a = '0; b = '0;
            if (dv_rose) begin
                got.push_back(tx_addr);
                if (got.size() == 2) begin v[0] = 1'b1; a[7:0] = 8'h20; end
                if (got.size() == 3) begin v[2] = 1'b1; a[23:16] = 8'h22; end
            end
            step(v, a, b, 1'b0);
            guard++;
        end
        n_cmp++; if (got.size() != 6) begin n_err++; $display("FAIL rr_count: got %0d frames required 6", got.size()); end
        for (int k = 0; k < got.size() && k < 6; k++) begin
            n_cmp++; if (got[k] !== want[k]) begin n_err++; $display("FAIL rr_order[%0d]: got %h required %h", k, got[k], want[k]); end
        end
        n_cmp++; if (overflow !== '0) begin n_err++; $display("FAIL rr_overflow: got %b required 0", overflow); end
        drain();
    endtask

    task automatic test_overflow();
        logic [8*N-1:0] a, b;
        int guard;
        fr_mode = 1; fr_wait_cfg = 3; fr_len_cfg = 10;
        a = '0; b = '0; a[15:8] = 8'h30;
        step(4'b0010, a, b, 1'b0);
        idle();
        a = '0; a[23:16] = 8'h31; b[23:16] = 8'hA1;
        step(4'b0100, a, b, 1'b0);
        n_cmp++; if (overflow !== '0) begin n_err++; $display("FAIL ovf_first: got %b required 0000", overflow); end
        a[23:16] = 8'h32; b[23:16] = 8'hA2;
        step(4'b0100, a, b, 1'b0);
        n_cmp++; if (overflow !== 4'b0100 || pending[2] !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b pend %b required 0100 pend[2]=1", overflow, pending); end
        a[23:16] = 8'h33;
        step(4'b0100, a, b, 1'b1);
        n_cmp++; if (overflow !== 4'b0100) begin n_err++; $display("FAIL ovf_set_beats_clear: got %b required 0100", overflow); end
        guard = 0;
        while (!dv_rose && guard < 100) begin idle(); guard++; end
        n_cmp++; if ({tx_addr, tx_buysell} !== 16'h31A1) begin n_err++; $display("FAIL ovf_kept_payload: got %h required 31a1", {tx_addr, tx_buysell}); end
        step('0, '0, '0, 1'b1);
        n_cmp++; if (overflow !== '0) begin n_err++; $display("FAIL ovf_clear: got %b required 0000", overflow); end
        drain();
    endtask

    task automatic test_refill();
        logic [8*N-1:0] a, b;
        int guard;
        fr_mode = 1; fr_wait_cfg = 0; fr_len_cfg = 2;
        a = '0; b = '0; a[7:0] = 8'h41; b[7:0] = 8'hB1;
        step(4'b0001, a, b, 1'b0);
        a[7:0] = 8'h42; b[7:0] = 8'hB2;
        step(4'b0001, a, b, 1'b0);
        n_cmp++; if (tx_dv !== 1'b1 || tx_addr !== 8'h41) begin n_err++; $display("FAIL refill_grant: got dv %b addr %h required 1 41", tx_dv, tx_addr); end
        n_cmp++; if (pending[0] !== 1'b1 || overflow !== '0) begin n_err++; $display("FAIL refill_slot: got pend %b ovf %b required pend[0]=1 ovf 0", pending, overflow); end
        guard = 0;
        idle();
        while (!dv_rose && guard < 100) begin idle(); guard++; end
        n_cmp++; if ({tx_addr, tx_buysell} !== 16'h42B2) begin n_err++; $display("FAIL refill_next: got %h required 42b2", {tx_addr, tx_buysell}); end
        drain();
    endtask

    task automatic test_timeout();
        logic [8*N-1:0] a, b;
        int guard, hi;
        fr_mode = 0;
        a = '0; b = '0; a[15:8] = 8'h51; a[31:24] = 8'h53;
        step(4'b1010, a, b, 1'b0);
        guard = 0;
        while (!dv_rose && guard < 20) begin idle(); guard++; end
        hi = dv_rose ? 1 : 0;
        guard = 0;
        while (tx_dv && guard < 200) begin
            idle(); guard++;
            if (tx_dv) hi++;
        end
        n_cmp++; if (hi != ACK) begin n_err++; $display("FAIL timeout_dv_cycles: got %0d required %0d", hi, ACK); end
        n_cmp++; if (timeout !== 1'b1 || tx_addr !== 8'h51) begin n_err++; $display("FAIL timeout_flag: got %b addr %h required 1 51", timeout, tx_addr); end
        fr_mode = 1; fr_wait_cfg = 0; fr_len_cfg = 2;
        idle();
        n_cmp++; if (tx_dv !== 1'b1 || tx_addr !== 8'h53) begin n_err++; $display("FAIL timeout_next_grant: got dv %b addr %h required 1 53", tx_dv, tx_addr); end
        drain();
        step('0, '0, '0, 1'b1);
        n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL timeout_clear: got %b required 0", timeout); end
    endtask

    task automatic test_random();
        logic [N-1:0] v;
        logic [8*N-1:0] a, b;
        logic [47:0] e;
        fr_mode = 2;
        exp_q.delete();
        for (int c = 0; c < 2200; c++) begin
            v = '0;
            if (c < 2000) for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 3) == 0);
            a = $urandom; b = $urandom;
            step(v, a, b, ($urandom_range(0, 31) == 0));
            n_cmp++; if (tx_dv !== m_dv) begin n_err++; $display("FAIL rnd_dv c%0d: got %b required %b", c, tx_dv, m_dv); end
            n_cmp++; if (pending !== m_full) begin n_err++; $display("FAIL rnd_pending c%0d: got %b required %b", c, pending, m_full); end
            n_cmp++; if ({overflow, timeout} !== {m_ovf, m_tmo}) begin n_err++; $display("FAIL rnd_flags c%0d: got %b required %b", c, {overflow, timeout}, {m_ovf, m_tmo}); end
            n_cmp++; if ({tx_addr, tx_buysell, tx_timestamp} !== {m_tx_addr, m_tx_bs, m_tx_ts}) begin n_err++; $display("FAIL rnd_payload c%0d: got %h required %h", c, {tx_addr, tx_buysell, tx_timestamp}, {m_tx_addr, m_tx_bs, m_tx_ts}); end
            if (dv_rose) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 48'hx;
                n_cmp++; if ({tx_addr, tx_buysell, tx_timestamp} !== e) begin n_err++; $display("FAIL rnd_frame c%0d: got %h required %h", c, {tx_addr, tx_buysell, tx_timestamp}, e); end
            end
        end
        drain();
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rnd_missing_frames: got %0d unsent required 0", exp_q.size()); end
    endtask

    task automatic test_async_reset();
        logic [8*N-1:0] a, b;
        int guard, spurious;
        fr_mode = 1; fr_wait_cfg = 1; fr_len_cfg = 30;
        for (int i = 0; i < N; i++) begin a[8*i +: 8] = 8'h60 + 8'(i); b[8*i +: 8] = 8'h90 + 8'(i); end
        step(4'hF, a, b, 1'b0);
        guard = 0;
        while (!m_acked && guard < 50) begin idle(); guard++; end
        n_cmp++; if ($countones(pending) != 3) begin n_err++; $display("FAIL arst_pre_pending: got %b required 3 set", pending); end
        #2 reset = 1'b1; tx_busy = 1'b0; req_valid = '0;
        #1;
        n_cmp++; if (tx_dv !== 1'b0 || pending !== '0) begin n_err++; $display("FAIL arst_immediate: got dv %b pend %b required 0 0", tx_dv, pending); end
        n_cmp++; if ({tx_addr, tx_timestamp} !== 40'h0) begin n_err++; $display("FAIL arst_payload: got %h required 0", {tx_addr, tx_timestamp}); end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        spurious = 0;
        repeat (30) begin idle(); if (tx_dv !== 1'b0) spurious++; end
        n_cmp++; if (spurious != 0) begin n_err++; $display("FAIL arst_spurious: got %0d cycles required 0", spurious); end
        a = '0; b = '0; a[31:24] = 8'h77;
        step(4'b1000, a, b, 1'b0);
        idle();
        n_cmp++; if (tx_dv !== 1'b1 || tx_addr !== 8'h77 || tx_timestamp !== 32'd30) begin n_err++; $display("FAIL arst_ts_restart: got dv %b addr %h ts %0d required 1 77 30", tx_dv, tx_addr, tx_timestamp); end
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_overflow();
        test_refill();
        test_timeout();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
